// File: rtl/bcd_counter_multi.sv
// rtl/bcd_counter_multi.sv - parametrised multi-digit BCD up/down counter
// Rippled digit steps, validated parallel load, wrap-or-saturate terminal handling.
module bcd_counter_multi #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] counter_out,
  output logic                carry_out,
  output logic                load_err,
  output logic                at_max,
  output logic                at_min
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] r_count;
  logic         r_carry;
  logic         r_load_err;

  logic [W-1:0] w_next;
  logic [3:0]   w_digit;
  logic         w_load_ok;
  logic         w_all9;
  logic         w_all0;
  logic         w_step;
  logic         w_terminal;

  // w_step carries "all lower digits were at the rollover value" up the chain.
  always_comb begin
    w_next    = r_count;
    w_digit   = 4'd0;
    w_load_ok = 1'b1;
    w_all9    = 1'b1;
    w_all0    = 1'b1;
    w_step    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) w_load_ok = 1'b0;
      w_digit = r_count[4*k +: 4];
      if (w_digit != 4'd9) w_all9 = 1'b0;
      if (w_digit != 4'd0) w_all0 = 1'b0;
      if (w_step) begin
        if (up) begin
          w_next[4*k +: 4] = (w_digit == 4'd9) ? 4'd0 : w_digit + 4'd1;
          w_step           = (w_digit == 4'd9);
        end else begin
          w_next[4*k +: 4] = (w_digit == 4'd0) ? 4'd9 : w_digit - 4'd1;
          w_step           = (w_digit == 4'd0);
        end
      end
    end
  end

  assign w_terminal = up ? w_all9 : w_all0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_carry    <= 1'b0;
      r_load_err <= !w_load_ok;
      if (w_load_ok) r_count <= load_val;
    end else if (en) begin
      r_load_err <= 1'b0;
      // Saturating mode parks at the terminal value without a carry pulse.
      if (w_terminal && !WRAP) begin
        r_carry <= 1'b0;
      end else begin
        r_count <= w_next;
        r_carry <= w_terminal;
      end
    end else begin
      r_carry    <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign counter_out = r_count;
  assign carry_out   = r_carry;
  assign load_err    = r_load_err;
  assign at_max      = w_all9;
  assign at_min      = w_all0;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// tb/tb_bcd_counter_multi.sv - directed bench for bcd_counter_multi
// Three instances: 4-digit wrap, 4-digit saturate, 1-digit wrap.
module tb_bcd_counter_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        w_reset = 1'b0, w_en = 1'b0, w_up = 1'b0, w_load = 1'b0;
  logic [15:0] w_val = '0, w_cnt;
  logic        w_carry, w_err, w_max, w_min;

  logic        s_reset = 1'b0, s_en = 1'b0, s_up = 1'b0, s_load = 1'b0;
  logic [15:0] s_val = '0, s_cnt;
  logic        s_carry, s_err, s_max, s_min;

  logic        d_reset = 1'b0, d_en = 1'b0, d_up = 1'b0, d_load = 1'b0;
  logic [3:0]  d_val = '0, d_cnt;
  logic        d_carry, d_err, d_max, d_min;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_counter_multi #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(w_reset), .en(w_en), .up(w_up), .load(w_load), .load_val(w_val),
    .counter_out(w_cnt), .carry_out(w_carry), .load_err(w_err), .at_max(w_max), .at_min(w_min)
  );

  bcd_counter_multi #(.DIGITS(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(s_reset), .en(s_en), .up(s_up), .load(s_load), .load_val(s_val),
    .counter_out(s_cnt), .carry_out(s_carry), .load_err(s_err), .at_max(s_max), .at_min(s_min)
  );

  bcd_counter_multi #(.DIGITS(1), .WRAP(1'b1)) u_d1 (
    .clk(clk), .reset(d_reset), .en(d_en), .up(d_up), .load(d_load), .load_val(d_val),
    .counter_out(d_cnt), .carry_out(d_carry), .load_err(d_err), .at_max(d_max), .at_min(d_min)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_w(input logic r, input logic l, input logic e, input logic u, input logic [15:0] v);
    w_reset = r; w_load = l; w_en = e; w_up = u; w_val = v;
    tick();
  endtask

  task automatic drv_s(input logic r, input logic l, input logic e, input logic u, input logic [15:0] v);
    s_reset = r; s_load = l; s_en = e; s_up = u; s_val = v;
    tick();
  endtask

  task automatic drv_d(input logic r, input logic l, input logic e, input logic u, input logic [3:0] v);
    d_reset = r; d_load = l; d_en = e; d_up = u; d_val = v;
    tick();
  endtask

  initial begin
    // Reset with en and load active: reset must dominate.
    w_reset = 1'b1; w_en = 1'b1; w_load = 1'b1; w_val = 16'h5555;
    s_reset = 1'b1; d_reset = 1'b1;
    tick();
    tick();
    check("rst_cnt",   w_cnt,   16'h0000);
    check("rst_carry", w_carry, 1'b0);
    check("rst_err",   w_err,   1'b0);
    check("rst_min",   w_min,   1'b1);
    check("rst_max",   w_max,   1'b0);
    check("rst_s_cnt", s_cnt,   16'h0000);
    check("rst_d_cnt", d_cnt,   4'h0);
    s_reset = 1'b0; d_reset = 1'b0;

    // Multi-digit ripple up.
    drv_w(0, 1, 0, 1, 16'h0998); check("ld_0998", w_cnt, 16'h0998);
    drv_w(0, 0, 1, 1, 16'h0000); check("up_0999", w_cnt, 16'h0999); check("up_0999_c", w_carry, 1'b0);
    drv_w(0, 0, 1, 1, 16'h0000); check("up_1000", w_cnt, 16'h1000); check("up_1000_c", w_carry, 1'b0);
    drv_w(0, 0, 1, 1, 16'h0000); check("up_1001", w_cnt, 16'h1001); check("up_1001_c", w_carry, 1'b0);

    // Wrap both directions.
    drv_w(0, 1, 0, 1, 16'h9999); check("ld_9999", w_cnt, 16'h9999); check("max_9999", w_max, 1'b1);
    drv_w(0, 0, 1, 1, 16'h0000); check("wrap_up", w_cnt, 16'h0000); check("wrap_up_c", w_carry, 1'b1);
    drv_w(0, 0, 0, 1, 16'h0000); check("idle_cnt", w_cnt, 16'h0000); check("idle_c", w_carry, 1'b0);
    drv_w(0, 0, 1, 0, 16'h0000); check("wrap_dn", w_cnt, 16'h9999); check("wrap_dn_c", w_carry, 1'b1);
    drv_w(0, 0, 1, 0, 16'h0000); check("dn_9998", w_cnt, 16'h9998); check("dn_9998_c", w_carry, 1'b0);
    drv_w(0, 0, 1, 1, 16'h0000); check("dir_up", w_cnt, 16'h9999);

    // Rejected load, then load priority over en.
    drv_w(0, 1, 0, 1, 16'h0042); check("ld_0042", w_cnt, 16'h0042);
    drv_w(0, 1, 0, 1, 16'h12A4); check("bad_cnt", w_cnt, 16'h0042); check("bad_err", w_err, 1'b1);
    drv_w(0, 0, 0, 1, 16'h0000); check("bad_err_clr", w_err, 1'b0); check("bad_hold", w_cnt, 16'h0042);
    drv_w(0, 1, 1, 1, 16'hF000); check("bad_top_cnt", w_cnt, 16'h0042); check("bad_top_err", w_err, 1'b1);
    drv_w(0, 1, 1, 1, 16'h0500); check("ld_en_cnt", w_cnt, 16'h0500); check("ld_en_err", w_err, 1'b0);

    // Reset mid-count.
    drv_w(0, 1, 0, 1, 16'h0123); check("ld_0123", w_cnt, 16'h0123);
    drv_w(0, 0, 1, 1, 16'h0000); check("up_0124", w_cnt, 16'h0124);
    drv_w(1, 0, 1, 1, 16'h0000); check("mid_rst", w_cnt, 16'h0000);
    drv_w(0, 0, 1, 1, 16'h0000); check("resume", w_cnt, 16'h0001);

    // Saturating instance.
    drv_s(0, 1, 0, 1, 16'h9999); check("s_ld", s_cnt, 16'h9999);
    for (int i = 0; i < 3; i++) begin
      drv_s(0, 0, 1, 1, 16'h0000);
      check("s_hold_max", s_cnt, 16'h9999);
      check("s_hold_c",   s_carry, 1'b0);
    end
    drv_s(0, 0, 1, 0, 16'h0000); check("s_dn", s_cnt, 16'h9998);
    drv_s(0, 1, 0, 0, 16'h0000); check("s_ld0", s_cnt, 16'h0000);
    drv_s(0, 0, 1, 0, 16'h0000); check("s_hold_min", s_cnt, 16'h0000); check("s_min_c", s_carry, 1'b0);
    check("s_at_min", s_min, 1'b1);
    drv_s(0, 0, 1, 1, 16'h0000); check("s_up", s_cnt, 16'h0001);

    // Single-digit instance.
    drv_d(0, 1, 0, 1, 4'h8); check("d_ld", d_cnt, 4'h8);
    drv_d(0, 0, 1, 1, 4'h0); check("d_9", d_cnt, 4'h9); check("d_9_c", d_carry, 1'b0);
    check("d_max", d_max, 1'b1);
    drv_d(0, 0, 1, 1, 4'h0); check("d_wrap", d_cnt, 4'h0); check("d_wrap_c", d_carry, 1'b1);
    drv_d(0, 0, 1, 0, 4'h0); check("d_dwrap", d_cnt, 4'h9); check("d_dwrap_c", d_carry, 1'b1);
    drv_d(0, 0, 1, 1, 4'h0); check("d_rewrap", d_cnt, 4'h0); check("d_rewrap_c", d_carry, 1'b1);
    drv_d(0, 1, 0, 1, 4'hA); check("d_bad", d_cnt, 4'h0); check("d_bad_err", d_err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
